i2c_cfg_sequencer: RTL and testbench
====================================

Name: i2c_cfg_sequencer

Overview:
- Parametrised I2C configuration sequencer.
- Walks an external register/value table and issues one 24-bit write (8-bit device address, 16-bit table word) per entry to the I2C serialiser via the mgo/mend/mack handshake.
- Generalises the fixed audio/video loader:
  - configurable table depth and two-device address split;
  - restartable runs;
  - done/busy status;
  - bounded NACK retry with error reporting (optional).
- Sits between the board-level config ROMs and the I2C bit engine.

Parameters:
- LUT_SIZE, 32: number of table entries walked (1..63).
- IDX_W, 6: width of lut_index; must satisfy 2**IDX_W > LUT_SIZE.
- DEV_SPLIT, 10: entries with index < DEV_SPLIT go to DEV0_ADDR, the rest to DEV1_ADDR.
- DEV0_ADDR, 8'h34: I2C write address of device 0 (codec).
- DEV1_ADDR, 8'h40: I2C write address of device 1 (video decoder).
- MAX_RETRY, 3: retries after a NACK before an entry is skipped (I2C_CFG_RETRY_EN only).
- AUTO_START, 1: 1 starts a run automatically after reset deassertion.

Ports:
- clk  in  1  system clock (50 kHz config clock).
- reset  in  1  synchronous, active-low reset.
- SCLK  in  1  I2C clock phase from bit engine; a transfer is launched only while high.
- start  in  1  single-cycle pulse; starts a run from IDLE or DONE, ignored while busy.
- lut_data  in  16  table word {reg addr, value} for the current lut_index (combinational ROM).
- mend  in  1  bit engine finished current transfer.
- mack  in  1  sampled with mend; 1 = all bytes acknowledged.
- lut_index  out  IDX_W  current table index.
- mgo  out  1  transfer request to bit engine.
- i2c_data  out  24  {device addr, lut_data}.
- mstep  out  4  state code: 0 LOAD, 1 WAIT, 2 NEXT, 3 IDLE, 4 DONE.
- busy  out  1  high in LOAD/WAIT/NEXT.
- done  out  1  high in DONE.
- err_flag  out  1  sticky, any entry skipped in this run.
- err_cnt  out  8  saturating count of skipped entries in this run.

Behaviour:
- Reset state (all edge-synchronous while reset=0):
  - state IDLE; lut_index 0; mgo 0; i2c_data 0; retry counter 0; err_flag 0; err_cnt 0.
  - Internal arm bit set to AUTO_START.
  - Reset mid-transfer drops mgo on the next edge; no partial state is retained.
- IDLE: go to LOAD when (arm or start). Entering LOAD clears arm, lut_index, retry counter, err_flag and err_cnt.
- LOAD:
  - Hold while SCLK=0; mgo stays 0.
  - On the first edge with SCLK=1:
    - i2c_data <= {(lut_index < DEV_SPLIT) ? DEV0_ADDR : DEV1_ADDR, lut_data};
    - mgo <= 1; go to WAIT.
  - lut_data is sampled on that same edge, so the ROM must be valid one cycle after lut_index changes.
- WAIT:
  - mgo held 1 and i2c_data held stable until mend=1.
  - On mend: mgo <= 0.
    - mack=1: go to NEXT.
    - mack=0: NACK handling (see Optional Feature).
  - mend and start together: start is ignored.
- NEXT:
  - Retry counter cleared.
  - If lut_index == LUT_SIZE-1: go to DONE; lut_index holds at LUT_SIZE-1.
  - Otherwise lut_index+1 and go to LOAD.
- DONE:
  - done=1, mgo=0, outputs hold.
  - start restarts the run as from IDLE.
- Latency: minimum 3 clk per entry (LOAD, WAIT with immediate mend, NEXT), plus SCLK wait and bit-engine time.
- err_cnt saturates at 8'hFF; err_flag and err_cnt are cleared only at run start or reset.
- Status outputs:
  - busy = state in {LOAD, WAIT, NEXT}; done = (state == DONE); both registered via state.
  - mstep is the state code, registered.

Optional Feature:
- Macro I2C_CFG_RETRY_EN.
- Defined: NACK in WAIT:
  - If retry counter < MAX_RETRY: increment it and go to LOAD (same entry resent).
  - Otherwise: err_flag <= 1; err_cnt +1 (saturating); go to NEXT (entry skipped).
  - Each entry gets at most 1+MAX_RETRY attempts.
- Undefined:
  - NACK always returns to LOAD and resends the same entry indefinitely (legacy behaviour).
  - No retry counter is built; err_flag and err_cnt are tied 0.

Test Plan:
- Reset release, AUTO_START=1, SCLK=1, bit engine ACKs every transfer after 2 cycles -> 32 transfers, lut_index 0..31:
  - indices 0..9 carry i2c_data[23:16]=8'h34, 10..31 carry 8'h40;
  - then done=1, busy=0, mstep=4.
- SCLK held 0 for 5 cycles in LOAD -> mgo stays 0 and mstep=0 for 5 cycles; mgo rises on the first edge with SCLK=1.
- With I2C_CFG_RETRY_EN, MAX_RETRY=3, entry 5 always NACKed -> 4 mgo pulses with identical i2c_data, then lut_index advances to 6; end state err_flag=1, err_cnt=1, done=1.
- Without the macro, entry 5 NACKed twice then ACKed -> 3 transfers of entry 5, err_flag=0, run completes normally.
- start pulse while busy -> ignored. start pulse in DONE -> lut_index=0, err_cnt=0, new 32-entry run.
- reset=0 asserted while in WAIT at index 12 -> next edge: mgo=0, lut_index=0, mstep=3; after release with AUTO_START=1 the run restarts at index 0.

Source files
------------

// File: rtl/i2c_cfg_sequencer.sv
// Walks a register/value table, issuing one 24-bit {dev addr, word} write per entry over the mgo/mend/mack handshake.
// Min 3 clk per entry plus SCLK wait and bit-engine time; stalls in LOAD/WAIT. Macro I2C_CFG_RETRY_EN enables bounded NACK retry.
module i2c_cfg_sequencer #(
  parameter int         LUT_SIZE   = 32,
  parameter int         IDX_W      = 6,
  parameter int         DEV_SPLIT  = 10,
  parameter logic [7:0] DEV0_ADDR  = 8'h34,
  parameter logic [7:0] DEV1_ADDR  = 8'h40,
  parameter int         MAX_RETRY  = 3,
  parameter bit         AUTO_START = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             SCLK,
  input  logic             start,
  input  logic [15:0]      lut_data,
  input  logic             mend,
  input  logic             mack,
  output logic [IDX_W-1:0] lut_index,
  output logic             mgo,
  output logic [23:0]      i2c_data,
  output logic [3:0]       mstep,
  output logic             busy,
  output logic             done,
  output logic             err_flag,
  output logic [7:0]       err_cnt
);

  if (LUT_SIZE < 1 || (1 << IDX_W) <= LUT_SIZE || MAX_RETRY < 0) begin : g_bad_params
    $error("i2c_cfg_sequencer: illegal LUT_SIZE/IDX_W/MAX_RETRY combination");
  end

  typedef enum logic [3:0] {
    ST_LOAD = 4'd0,
    ST_WAIT = 4'd1,
    ST_NEXT = 4'd2,
    ST_IDLE = 4'd3,
    ST_DONE = 4'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LUT_SIZE - 1);
  localparam logic [IDX_W:0]   SPLIT    = (IDX_W + 1)'(DEV_SPLIT);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             mgo_q, mgo_d;
  logic [23:0]      data_q, data_d;
  logic             arm_q, arm_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             run_start;
  logic             nack_give_up;

  assign run_start = ((state_q == ST_IDLE) && (arm_q || start)) ||
                     ((state_q == ST_DONE) && start);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mgo_d   = mgo_q;
    data_d  = data_q;
    arm_d   = arm_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (run_start) begin
          state_d = ST_LOAD;
          arm_d   = 1'b0;
          idx_d   = '0;
        end
      end
      ST_LOAD: begin
        // lut_data is only trusted here, a full cycle after lut_index settled
        if (SCLK) begin
          data_d  = {(({1'b0, idx_q} < SPLIT) ? DEV0_ADDR : DEV1_ADDR), lut_data};
          mgo_d   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mend) begin
          mgo_d   = 1'b0;
          state_d = (mack || nack_give_up) ? ST_NEXT : ST_LOAD;
        end
      end
      ST_NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_LOAD) || (state_d == ST_WAIT) || (state_d == ST_NEXT);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      mgo_q   <= 1'b0;
      data_q  <= '0;
      arm_q   <= AUTO_START;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mgo_q   <= mgo_d;
      data_q  <= data_d;
      arm_q   <= arm_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef I2C_CFG_RETRY_EN
  localparam int           RW        = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  logic [RW-1:0] retry_q, retry_d;
  logic          err_flag_q, err_flag_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  assign nack_give_up = (retry_q >= RETRY_MAX);

  always_comb begin
    retry_d    = retry_q;
    err_flag_d = err_flag_q;
    err_cnt_d  = err_cnt_q;
    if (run_start) begin
      retry_d    = '0;
      err_flag_d = 1'b0;
      err_cnt_d  = '0;
    end else if ((state_q == ST_WAIT) && mend && !mack) begin
      if (!nack_give_up) begin
        retry_d = retry_q + 1'b1;
      end else begin
        err_flag_d = 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end
    end else if (state_q == ST_NEXT) begin
      retry_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      retry_q    <= '0;
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      retry_q    <= retry_d;
      err_flag_q <= err_flag_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign err_flag = err_flag_q;
  assign err_cnt  = err_cnt_q;
`else
  // Legacy loader: a NACKed entry is resent until it is acknowledged
  assign nack_give_up = 1'b0;
  assign err_flag     = 1'b0;
  assign err_cnt      = 8'h00;
`endif

  assign lut_index = idx_q;
  assign mgo       = mgo_q;
  assign i2c_data  = data_q;
  assign mstep     = state_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Randomised bench for i2c_cfg_sequencer: bench-side bit engine and ROM, transaction-level model checked every cycle.
module tb_i2c_cfg_sequencer;
  localparam int LAST = 31;
`ifdef I2C_CFG_RETRY_EN
  localparam int MAX_RETRY = 3;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        SCLK = 1'b1;
  logic        start = 1'b0;
  logic        mend = 1'b0;
  logic        mack = 1'b0;
  logic [15:0] lut_data;
  logic [5:0]  lut_index;
  logic        mgo;
  logic [23:0] i2c_data;
  logic [3:0]  mstep;
  logic        busy, done, err_flag;
  logic [7:0]  err_cnt;
  logic [15:0] rom [64];

  assign lut_data = rom[lut_index];
  always #5 clk = ~clk;

  i2c_cfg_sequencer dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .start(start), .lut_data(lut_data),
    .mend(mend), .mack(mack), .lut_index(lut_index), .mgo(mgo), .i2c_data(i2c_data),
    .mstep(mstep), .busy(busy), .done(done), .err_flag(err_flag), .err_cnt(err_cnt)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // 0: ack after 2 cycles, SCLK high; 1: random; 2: entry 5 NACKed, SCLK hold at entry 3
  int mode = 0;

  typedef enum {P_RST, P_RUN, P_FIN, P_DONE} phase_e;
  phase_e     ph = P_RST;
  int         exp_idx = 0, tries = 0, cd = 0, run_cyc = 0, done_cyc = 0, xfers = 0;
  int         att [64];
  logic [7:0] addr_seen [64];
  int         m_err_cnt = 0;
  bit         m_err_flag = 1'b0;
  bit         prev_go = 1'b0, mgo_prev = 1'b0;
  int         low_cur = 0, low_max = 0;

  function automatic logic [23:0] exp_word(input int i);
    return {(i < 10) ? 8'h34 : 8'h40, rom[i]};
  endfunction

  task automatic new_run();
    ph = P_RUN; exp_idx = 0; tries = 0; run_cyc = 0; xfers = 0;
    m_err_cnt = 0; m_err_flag = 1'b0;
    for (int i = 0; i < 64; i++) begin att[i] = 0; addr_seen[i] = 8'h00; end
  endtask

  task automatic advance();
    if (exp_idx == LAST) begin ph = P_FIN; cd = 2; end
    else exp_idx++;
    tries = 0;
  endtask

  // Compare process: outputs at each negedge reflect the previous edge; inputs seen here drive the next one
  initial begin
    bit rise;
    forever begin
      @(negedge clk);
      rise = mgo && !mgo_prev;
      if (ph == P_RUN || ph == P_FIN) begin
        run_cyc++;
        if (ph == P_FIN) begin
          cd--;
          if (cd == 0) begin ph = P_DONE; done_cyc = run_cyc; end
        end
      end
      case (ph)
        P_RST: begin
          chk("rst_mgo", 32'(mgo), 32'd0);
          chk("rst_index", 32'(lut_index), 32'd0);
          chk("rst_mstep", 32'(mstep), 32'd3);
          chk("rst_data", 32'(i2c_data), 32'd0);
          chk("rst_status", 32'({busy, done, err_flag, err_cnt}), 32'd0);
        end
        P_RUN, P_FIN: begin
          chk("run_busy", 32'(busy), 32'd1);
          chk("run_done", 32'(done), 32'd0);
          chk("run_mstep_range", 32'(mstep <= 4'd2), 32'd1);
          chk("mgo_launch", 32'(rise), 32'(prev_go));
          if (mgo) begin
            chk("xfer_index", 32'(lut_index), 32'(exp_idx));
            chk("xfer_data", 32'(i2c_data), 32'(exp_word(exp_idx)));
          end
          chk("run_err", 32'({err_flag, err_cnt}), 32'({m_err_flag, 8'(m_err_cnt)}));
          if (rise) begin
            att[exp_idx]++; tries++; xfers++;
            addr_seen[exp_idx] = i2c_data[23:16];
          end
        end
        P_DONE: begin
          chk("done_flag", 32'(done), 32'd1);
          chk("done_busy", 32'(busy), 32'd0);
          chk("done_mstep", 32'(mstep), 32'd4);
          chk("done_mgo", 32'(mgo), 32'd0);
          chk("done_index", 32'(lut_index), 32'(LAST));
          chk("done_err", 32'({err_flag, err_cnt}), 32'({m_err_flag, 8'(m_err_cnt)}));
        end
        default: ;
      endcase
      if (mode == 2 && ph == P_RUN && reset && mstep == 4'd0 && !mgo && !SCLK) begin
        low_cur++;
        if (low_cur > low_max) low_max = low_cur;
      end else begin
        low_cur = 0;
      end
      if (!reset) begin
        ph = P_RST;
      end else begin
        case (ph)
          P_RST:  new_run();
          P_RUN: begin
            if (mgo && mend) begin
              if (mack) advance();
`ifdef I2C_CFG_RETRY_EN
              else if (tries >= 1 + MAX_RETRY) begin
                m_err_flag = 1'b1;
                if (m_err_cnt < 255) m_err_cnt++;
                advance();
              end
`endif
            end
          end
          P_DONE: if (start) new_run();
          default: ;
        endcase
      end
      prev_go  = (ph == P_RUN) && reset && (mstep == 4'd0) && !mgo && SCLK;
      mgo_prev = mgo;
    end
  end

  // Bit engine and SCLK source
  initial begin
    int wcnt = 2;
    bit sent = 1'b0;
    int hold_cnt = 0;
    bit hold_done = 1'b0;
    int n5 = 0;
    forever begin
      @(posedge clk); #2;
      mend = 1'b0; mack = 1'b0;
      if (mode != 2) begin hold_done = 1'b0; n5 = 0; end
      if (mgo === 1'b1 && !sent) begin
        if (wcnt == 0) begin
          mend = 1'b1; sent = 1'b1;
          if (mode == 1) mack = ($urandom_range(0, 3) != 0);
          else if (mode == 2 && lut_index == 6'd5) begin
`ifdef I2C_CFG_RETRY_EN
            mack = 1'b0;
`else
            mack = (n5 >= 2);
`endif
            n5++;
          end else mack = 1'b1;
        end else wcnt--;
      end else if (mgo !== 1'b1) begin
        sent = 1'b0;
        wcnt = (mode == 1) ? int'($urandom_range(0, 3)) : ((mode == 2) ? 1 : 2);
      end
      if (mode == 2 && !hold_done && lut_index == 6'd3 && mstep == 4'd0 && !mgo) begin
        hold_cnt = 5; hold_done = 1'b1;
      end
      if (hold_cnt > 0) begin SCLK = 1'b0; hold_cnt--; end
      else if (mode == 1) SCLK = ($urandom_range(0, 3) != 0);
      else SCLK = 1'b1;
    end
  end

  task automatic wait_done(input int bound, input bit rnd);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #2;
      start = rnd && busy && ($urandom_range(0, 11) == 0);
      if (done) begin ok = 1'b1; break; end
    end
    start = 1'b0;
    chk("run_completes", 32'(ok), 32'd1);
    @(negedge clk); #1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    chk("restart_index", 32'(lut_index), 32'd0);
    chk("restart_err_cnt", 32'(err_cnt), 32'd0);
    chk("restart_mstep", 32'(mstep), 32'd0);
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 64; i++) rom[i] = 16'($urandom);
    reset = 1'b0; mode = 0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;

    // Auto-started run: 5 clk per entry with a 2-cycle ack
    wait_done(2000, 1'b0);
    chk("run1_xfers", 32'(xfers), 32'd32);
    chk("run1_cycles", 32'(done_cyc), 32'd161);
    chk("run1_addr0", 32'(addr_seen[0]), 32'h34);
    chk("run1_addr9", 32'(addr_seen[9]), 32'h34);
    chk("run1_addr10", 32'(addr_seen[10]), 32'h40);
    chk("run1_addr31", 32'(addr_seen[31]), 32'h40);
    chk("run1_end", 32'({done, busy, mstep}), 32'h24);

    // Random SCLK, latency, NACKs and ignored mid-run starts
    mode = 1;
    pulse_start();
    wait_done(6000, 1'b1);
    chk("run2_min_xfers", 32'(xfers >= 32), 32'd1);

    // Entry 5 NACKed, SCLK held low in LOAD of entry 3
    mode = 2;
    pulse_start();
    wait_done(3000, 1'b0);
`ifdef I2C_CFG_RETRY_EN
    chk("e5_attempts", 32'(att[5]), 32'd4);
    chk("e5_err", 32'({err_flag, err_cnt}), 32'h101);
`else
    chk("e5_attempts", 32'(att[5]), 32'd3);
    chk("e5_err", 32'({err_flag, err_cnt}), 32'h000);
`endif
    chk("e6_attempts", 32'(att[6]), 32'd1);
    chk("sclk_hold_cycles", 32'(low_max), 32'd5);

    // Reset while waiting on entry 12
    mode = 0;
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #2;
      if (mgo && lut_index == 6'd12) begin found = 1'b1; break; end
    end
    chk("reach_idx12", 32'(found), 32'd1);
    reset = 1'b0;
    @(posedge clk); #2;
    chk("midrst_mgo", 32'(mgo), 32'd0);
    chk("midrst_index", 32'(lut_index), 32'd0);
    chk("midrst_mstep", 32'(mstep), 32'd3);
    reset = 1'b1;
    wait_done(2000, 1'b0);
    chk("run4_xfers", 32'(xfers), 32'd32);
    chk("run4_cycles", 32'(done_cyc), 32'd161);
    chk("run4_idx0_once", 32'(att[0]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
